seq_mon_ctrl: RTL

SEQ_MON_CTRL -- requirements
Module: seq_mon_ctrl

---
 rtl/seq_mon_ctrl.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/seq_mon_ctrl.sv
// Edge-density monitor: counts rising edges of sig_in over a sliding window
// and raises a level interrupt when the count reaches a threshold.
module seq_mon_ctrl #(
   parameter int CNT_W = 8,
   parameter int HO_W  = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             sig_in,
   input  logic             arm,
   input  logic             disarm,
   input  logic [3:0]       cfg_window,
   input  logic [3:0]       cfg_thresh,
   input  logic [HO_W-1:0]  cfg_holdoff,
   input  logic             irq_ack,
   output logic             irq,
   output logic             busy,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] hit_count
);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_ARMED    = 2'd1,
      ST_DETECTED = 2'd2,
      ST_HOLDOFF  = 2'd3
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic             r_sig_prev;
   logic             w_rise;
   logic [14:0]      r_hist;
   logic [14:0]      w_mask;
   logic [14:0]      w_masked;
   logic [3:0]       r_win;
   logic [3:0]       r_thr;
   logic [3:0]       w_win_eff;
   logic [3:0]       w_thr_eff;
   logic [3:0]       w_pop;
   logic             w_detect;
   logic [HO_W-1:0]  r_holdoff;
   logic [HO_W-1:0]  r_ho_cnt;
   logic             r_irq;
   logic [CNT_W-1:0] r_hits;
   logic             w_enter_armed;
   logic             w_accept_arm;

   assign w_rise    = sig_in & ~r_sig_prev;
   assign w_win_eff = (r_win == 4'd0) ? 4'd1 : r_win;
   assign w_thr_eff = (r_thr == 4'd0) ? 4'd1 : r_thr;

   // Low W bits set; W=15 shifts every bit out, leaving the full mask.
   assign w_mask   = ~(15'h7FFF << w_win_eff);
   assign w_masked = r_hist & w_mask;

   always_comb begin
      w_pop = '0;
      for (int unsigned i = 0; i < 15; i++) begin
         w_pop = w_pop + {3'd0, w_masked[i]};
      end
   end

   assign w_detect = (w_pop >= w_thr_eff);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (disarm) begin
         w_state_nxt = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE:     if (arm) w_state_nxt = ST_ARMED;
            ST_ARMED:    if (w_detect) w_state_nxt = ST_DETECTED;
            ST_DETECTED: if (irq_ack) w_state_nxt = (r_holdoff != '0) ? ST_HOLDOFF : ST_ARMED;
            ST_HOLDOFF:  if (r_ho_cnt == HO_W'(1)) w_state_nxt = ST_ARMED;
            default:     w_state_nxt = ST_IDLE;
         endcase
      end
   end

   assign w_enter_armed = (w_state_nxt == ST_ARMED) && (r_state != ST_ARMED);
   assign w_accept_arm  = (r_state == ST_IDLE) && (w_state_nxt == ST_ARMED);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sig_prev <= 1'b0;
         r_hist     <= '0;
         r_win      <= '0;
         r_thr      <= '0;
         r_holdoff  <= '0;
         r_ho_cnt   <= '0;
         r_irq      <= 1'b0;
         r_hits     <= '0;
      end else begin
         r_sig_prev <= sig_in;

         if (disarm || w_enter_armed) begin
            r_hist <= '0;
         end else if (r_state == ST_ARMED) begin
            r_hist <= {r_hist[13:0], w_rise};
         end

         if (w_accept_arm) begin
            r_win     <= cfg_window;
            r_thr     <= cfg_thresh;
            r_holdoff <= cfg_holdoff;
         end

         // Counter is loaded on entry, so its value equals the cycles left.
         if (w_state_nxt == ST_HOLDOFF && r_state != ST_HOLDOFF) begin
            r_ho_cnt <= r_holdoff;
         end else if (w_state_nxt == ST_HOLDOFF) begin
            r_ho_cnt <= r_ho_cnt - HO_W'(1);
         end else begin
            r_ho_cnt <= '0;
         end

         r_irq <= (w_state_nxt == ST_DETECTED);

         if (w_accept_arm) begin
            r_hits <= '0;
         end else if (r_state == ST_ARMED && w_state_nxt == ST_DETECTED && r_hits != '1) begin
            r_hits <= r_hits + CNT_W'(1);
         end
      end
   end

   assign irq       = r_irq;
   assign busy      = (r_state != ST_IDLE);
   assign state     = r_state;
   assign hit_count = r_hits;

endmodule
